// File: rtl/div_unit_pkg.sv
// div_unit_pkg: M-extension divide-group encodings
// shared by the ex stage and the divider.
package div_unit_pkg;

  localparam logic [6:0] INST_TYPE_M = 7'b0110011;
  localparam logic [6:0] FUNCT7_M    = 7'b0000001;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam int CNT_W = 6;

  // Signed variants negate magnitudes and fix up signs.
  function automatic logic op_signed(input logic [2:0] op);
    return (op == INST_DIV) || (op == INST_REM);
  endfunction

  // Remainder variants return the partial remainder.
  function automatic logic op_rem(input logic [2:0] op);
    return (op == INST_REM) || (op == INST_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 divider
// for DIV/DIVU/REM/REMU with cancel and hold.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            cancel_i,
  output logic            busy_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_wen_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] zero_res;

  // Operand magnitudes and sign flags at acceptance.
  always_comb begin
    a_neg = op_signed(op_i) & dividend_i[XLEN-1];
    b_neg = op_signed(op_i) & divisor_i[XLEN-1];
    a_mag = a_neg ? ('0 - dividend_i) : dividend_i;
    b_mag = b_neg ? ('0 - divisor_i) : divisor_i;
    zero_res = op_rem(op_i) ? dividend_i : '1;
  end

  // One restoring step: shift in next dividend bit, trial subtract.
  always_comb begin
    trial = {rem_q, dvd_q[XLEN-1]};
    diff  = trial - {1'b0, dvs_q};
    fits  = ~diff[XLEN];
  end

  // Sign fix-up and op select for the final result.
  always_comb begin
    quo_fix = neg_quo_q ? ('0 - dvd_q) : dvd_q;
    rem_fix = neg_rem_q ? ('0 - rem_q) : rem_q;
    result  = op_rem(op_q) ? rem_fix : quo_fix;
  end

  // Hold request: acceptance cycle plus every CALC cycle.
  assign busy_o = ~rst & (((state == S_IDLE) & start_i) |
                          (state == S_CALC));

  // Control FSM with datapath and registered write-back outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rd_data_o <= '0;
      rd_addr_o <= '0;
      reg_wen_o <= 1'b0;
    end else begin
      rd_data_o <= '0;
      rd_addr_o <= '0;
      reg_wen_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            op_q      <= op_i;
            rd_q      <= rd_addr_i;
            dvd_q     <= a_mag;
            dvs_q     <= b_mag;
            rem_q     <= '0;
            cnt       <= '0;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (divisor_i == '0) begin
              state     <= S_DONE;
              rd_data_o <= zero_res;
              rd_addr_o <= rd_addr_i;
              reg_wen_o <= (rd_addr_i != 5'd0);
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cancel_i) begin
            state <= S_IDLE;
          end else if (cnt == CNT_W'(XLEN)) begin
            state     <= S_DONE;
            rd_data_o <= result;
            rd_addr_o <= rd_q;
            reg_wen_o <= (rd_q != 5'd0);
          end else begin
            cnt   <= cnt + 1'b1;
            dvd_q <= {dvd_q[XLEN-2:0], fits};
            rem_q <= fits ? diff[XLEN-1:0] : trial[XLEN-1:0];
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit results,
// latency, busy, cancel, x0 and reset behaviour.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        cancel_i;
  logic        busy_o;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o;

  int n_chk  = 0;
  int n_fail = 0;

  div_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .cancel_i   (cancel_i),
    .busy_o     (busy_o),
    .rd_data_o  (rd_data_o),
    .rd_addr_o  (rd_addr_o),
    .reg_wen_o  (reg_wen_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Drive a request; acceptance edge is the posedge inside.
  task automatic issue(input string tag,
                       input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    rd_addr_i  = rd;
    #1;
    chk({tag, "_busy_acc"}, 32'(busy_o), 32'd1);
    @(posedge clk);
    #1;
    start_i    = 1'b0;
    op_i       = 3'($urandom);
    dividend_i = $urandom;
    divisor_i  = $urandom;
    rd_addr_i  = 5'($urandom);
  endtask

  // Count negedges after acceptance until the write strobe.
  task automatic wait_done(output int lat,
                           output logic [31:0] d,
                           output logic [4:0] a,
                           output bit busy_ok);
    lat = -1;
    d = '0;
    a = '0;
    busy_ok = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (reg_wen_o) begin
        lat = n;
        d = rd_data_o;
        a = rd_addr_o;
        if (busy_o) busy_ok = 1'b0;
        return;
      end
      if (!busy_o) busy_ok = 1'b0;
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] rd,
                       input logic [31:0] exp_d,
                       input int exp_lat,
                       input bit post_chk);
    int          lat;
    logic [31:0] d;
    logic [4:0]  ra;
    bit          bok;
    issue(tag, op, a, b, rd);
    wait_done(lat, d, ra, bok);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, d, exp_d);
    chk({tag, "_addr"}, 32'(ra), 32'(rd));
    chk({tag, "_busy"}, 32'(bok), 32'd1);
    if (post_chk) begin
      @(negedge clk);
      chk({tag, "_wen_after"}, 32'(reg_wen_o), 32'd0);
      chk({tag, "_data_after"}, rd_data_o, 32'd0);
    end
  endtask

  initial begin
    int          seen;
    int          lat;
    logic        b33;
    logic        b34;
    logic [31:0] d;
    logic [4:0]  ra;

    rst        = 1'b1;
    start_i    = 1'b0;
    cancel_i   = 1'b0;
    op_i       = INST_DIV;
    dividend_i = '0;
    divisor_i  = '0;
    rd_addr_i  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_wen", 32'(reg_wen_o), 32'd0);
    chk("rst_data", rd_data_o, 32'd0);
    chk("rst_addr", 32'(rd_addr_o), 32'd0);
    rst = 1'b0;

    do_op("divu_100_7", INST_DIVU, 32'd100, 32'd7, 5'd5,
          32'd14, 34, 1'b0);
    do_op("remu_100_7", INST_REMU, 32'd100, 32'd7, 5'd6,
          32'd2, 34, 1'b1);
    do_op("div_m7_2", INST_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7,
          32'hFFFF_FFFD, 34, 1'b1);
    do_op("rem_m7_2", INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd8,
          32'hFFFF_FFFF, 34, 1'b1);
    do_op("div_7_m2", INST_DIV, 32'd7, 32'hFFFF_FFFE, 5'd9,
          32'hFFFF_FFFD, 34, 1'b1);
    do_op("rem_7_m2", INST_REM, 32'd7, 32'hFFFF_FFFE, 5'd10,
          32'd1, 34, 1'b1);
    do_op("div_5_0", INST_DIV, 32'd5, 32'd0, 5'd11,
          32'hFFFF_FFFF, 1, 1'b1);
    do_op("divu_5_0", INST_DIVU, 32'd5, 32'd0, 5'd12,
          32'hFFFF_FFFF, 1, 1'b1);
    do_op("rem_5_0", INST_REM, 32'd5, 32'd0, 5'd13,
          32'd5, 1, 1'b1);
    do_op("div_ovf", INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
          5'd14, 32'h8000_0000, 34, 1'b1);
    do_op("rem_ovf", INST_REM, 32'h8000_0000, 32'hFFFF_FFFF,
          5'd15, 32'd0, 34, 1'b1);
    do_op("divu_big", INST_DIVU, 32'hFFFF_FFFF, 32'd16,
          5'd16, 32'h0FFF_FFFF, 34, 1'b1);

    // x0 destination: full latency, no strobe.
    issue("x0", INST_DIVU, 32'd100, 32'd7, 5'd0);
    seen = 0;
    b33 = 1'b0;
    b34 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (reg_wen_o) seen++;
      if (rd_addr_o != 5'd0) seen++;
      if (n == 33) b33 = busy_o;
      if (n == 34) b34 = busy_o;
    end
    chk("x0_no_wen", 32'(seen), 32'd0);
    chk("x0_busy33", 32'(b33), 32'd1);
    chk("x0_busy34", 32'(b34), 32'd0);

    // Cancel at CALC cycle 10, restart two cycles later.
    issue("cancel10", INST_DIVU, 32'd100, 32'd7, 5'd17);
    seen = 0;
    b33 = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (reg_wen_o) seen++;
      if (n == 11) begin
        b33 = busy_o;
        cancel_i = 1'b0;
      end
      if (n == 10) cancel_i = 1'b1;
    end
    chk("cancel10_busy", 32'(b33), 32'd0);
    chk("cancel10_no_wen", 32'(seen), 32'd0);
    do_op("after_cancel", INST_DIVU, 32'd1000, 32'd10,
          5'd18, 32'd100, 34, 1'b1);

    // Cancel on the final CALC cycle beats completion.
    issue("cancel_last", INST_REMU, 32'd100, 32'd7, 5'd19);
    seen = 0;
    b34 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (reg_wen_o) seen++;
      if (n == 34) begin
        b34 = busy_o;
        cancel_i = 1'b0;
      end
      if (n == 33) cancel_i = 1'b1;
    end
    chk("cancel_last_busy", 32'(b34), 32'd0);
    chk("cancel_last_no_wen", 32'(seen), 32'd0);

    // Start while busy is ignored.
    issue("busy_start", INST_DIVU, 32'd100, 32'd7, 5'd3);
    lat = -1;
    d = '0;
    ra = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (reg_wen_o) begin
        lat = n;
        d = rd_data_o;
        ra = rd_addr_o;
        break;
      end
      if (n == 5) begin
        start_i    = 1'b1;
        op_i       = INST_REMU;
        dividend_i = 32'd50;
        divisor_i  = 32'd0;
        rd_addr_i  = 5'd9;
      end
      if (n == 9) start_i = 1'b0;
    end
    chk("busy_start_lat", 32'(lat), 32'd34);
    chk("busy_start_data", d, 32'd14);
    chk("busy_start_addr", 32'(ra), 32'd3);

    // Back-to-back acceptance right after DONE.
    do_op("b2b_a", INST_DIVU, 32'd81, 32'd9, 5'd20,
          32'd9, 34, 1'b0);
    do_op("b2b_b", INST_REMU, 32'd83, 32'd9, 5'd21,
          32'd2, 34, 1'b1);

    // Reset in the middle of CALC.
    issue("rst_mid", INST_DIVU, 32'd100, 32'd7, 5'd22);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    chk("rst_mid_wen", 32'(reg_wen_o), 32'd0);
    chk("rst_mid_data", rd_data_o, 32'd0);
    chk("rst_mid_addr", 32'(rd_addr_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (reg_wen_o) seen++;
      if (busy_o) seen++;
    end
    chk("rst_mid_idle", 32'(seen), 32'd0);
    do_op("after_rst", INST_DIV, 32'hFFFF_FF9C, 32'd7,
          5'd23, 32'hFFFF_FFF2, 34, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have ports: clk  input  1  core clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  asynchronous reset, active-high.
REQ-003 SHALL have ports: start_i  input  1  request pulse from the id_ex stage, sampled only in IDLE.
REQ-004 SHALL have ports: op_i  input  3  func3 of the M-extension divide group: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have ports: dividend_i  input  32  op1 value.
REQ-006 SHALL have ports: divisor_i  input  32  op2 value.
REQ-007 SHALL have ports: rd_addr_i  input  5  destination register.
REQ-008 SHALL have ports: cancel_i  input  1  jump flush from ctrl, aborts the operation in flight.
REQ-009 SHALL have ports: busy_o  output  1  hold request to ctrl, high from acceptance until result.
REQ-010 SHALL have ports: rd_data_o  output  32  result.
REQ-011 SHALL have ports: rd_addr_o  output  5  destination register.
REQ-012 SHALL have ports: reg_wen_o  output  1  one-cycle write strobe to regs.
REQ-013 SHALL have parameter: XLEN, default 32, datapath width.

Function
REQ-014 SHALL implement the states IDLE, CALC and DONE.
- IDLE->CALC: start_i=1 with nonzero divisor.
- IDLE->DONE: start_i=1 with zero divisor.
- CALC->DONE: after 32 iterations.
- DONE->IDLE: unconditionally.
REQ-015 SHALL latch op_i, rd_addr_i and the operand magnitudes on acceptance, so inputs may change afterwards.
REQ-016 SHALL, in CALC, use restoring radix-2 division, one quotient bit per cycle, MSB first, with a 6-bit iteration counter.
REQ-017 SHALL assert busy_o combinationally in the acceptance cycle and in every CALC cycle, and deassert it in DONE.
REQ-018 SHALL give a latency of 34 cycles from acceptance edge to the reg_wen_o cycle for nonzero divisors, and 1 cycle for a zero divisor.
REQ-019 SHALL assert reg_wen_o for exactly one cycle (DONE), with rd_data_o and rd_addr_o valid in that cycle and zero otherwise.
REQ-020 SHALL, for signed ops, divide magnitudes, negate the quotient when operand signs differ, and give the remainder the dividend's sign.
REQ-021 SHALL handle divide by zero as: quotient 32'hFFFF_FFFF for both DIV and DIVU, and remainder = dividend.
REQ-022 SHALL handle signed overflow (32'h8000_0000 / 32'hFFFF_FFFF) as: DIV quotient 32'h8000_0000, REM 0, with no special path (falls out of the magnitude arithmetic).
REQ-023 SHALL force rd_addr_o=0 and reg_wen_o=0 when rd_addr is x0, while still completing the full latency.
REQ-024 SHALL, when cancel_i=1 in any non-IDLE state, return to IDLE next edge with no reg_wen_o pulse; cancel_i in IDLE is ignored.
REQ-025 SHALL give cancel_i priority over completion when cancel_i coincides with the last CALC cycle.
REQ-026 SHALL ignore start_i while not IDLE, and accept a new start in the cycle after DONE.

Reset
REQ-027 SHALL, on rst=1, immediately place the state in IDLE and clear the counter, latched operands, rd_data_o, rd_addr_o, reg_wen_o and busy_o to 0.
REQ-028 SHALL, on reset mid-CALC, discard the operation without a write strobe.

Structure
REQ-029 SHALL place the INST_DIV/DIVU/REM/REMU func3 codes and the M-extension opcode/func7 (0000001) in the shared defines.v.
REQ-030 SHALL keep the state encoding local to the module.
REQ-031 SHALL be a single module with no sub-module; the ex stage muxes its outputs onto the regs write port and ORs busy_o into hold_flag_o.

Verification
REQ-032 SHALL cover: DIVU 100/7 -> after 34 cycles, one reg_wen_o pulse, rd_data_o=14; REMU -> 2.
REQ-033 SHALL cover: DIV -7/2 -> 32'hFFFF_FFFD (-3); REM -7/2 -> 32'hFFFF_FFFF (-1).
REQ-034 SHALL cover: DIV 5/0 -> 32'hFFFF_FFFF one cycle later; REM 5/0 -> 5; busy_o high for exactly the acceptance cycle.
REQ-035 SHALL cover: DIV 32'h8000_0000/-1 -> 32'h8000_0000; REM -> 0.
REQ-036 SHALL cover: cancel_i at CALC cycle 10 -> IDLE next cycle, no reg_wen_o; a new start 2 cycles later completes correctly.
REQ-037 SHALL cover: rst asserted mid-CALC -> all outputs 0 asynchronously; start_i while busy ignored, result reflects the first operands.
